lcd_reader: RTL and testbench

LCD_READER -- requirements
Module: lcd_reader

---
 rtl/lcd_reader_if.sv | 26 ++
 rtl/lcd_reader.sv | 111 +++++++++++
 tb/tb_lcd_reader.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/lcd_reader_if.sv
// rtl/lcd_reader_if.sv - request/result and LCD bus signals of the LCD read sequencer
interface lcd_reader_if;
    logic       req;
    logic       rs_sel;
    logic       poll;
    logic [7:0] DB_in;
    logic       RS;
    logic       RW;
    logic       E;
    logic [7:0] rd_data;
    logic       busy_flag;
    logic [6:0] addr;
    logic       done;
    logic       timeout;
    logic       idle;

    modport slave (
        input  req, rs_sel, poll, DB_in,
        output RS, RW, E, rd_data, busy_flag, addr, done, timeout, idle
    );

    modport master (
        output req, rs_sel, poll, DB_in,
        input  RS, RW, E, rd_data, busy_flag, addr, done, timeout, idle
    );
endinterface

// File: rtl/lcd_reader.sv
// rtl/lcd_reader.sv - HD44780-style LCD read sequencer with optional busy-flag polling
module lcd_reader #(
    parameter int SETUP_CYC  = 2,
    parameter int E_HIGH_CYC = 12,
    parameter int E_LOW_CYC  = 13,
    parameter int POLL_LIMIT = 1000
) (
    input  logic         clk,
    input  logic         rst,
    lcd_reader_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, SETUP, EHIGH, HOLD, DONE} state_t;

    localparam logic [7:0]  SETUP_LD = 8'(SETUP_CYC - 1);
    localparam logic [7:0]  EHIGH_LD = 8'(E_HIGH_CYC - 1);
    localparam logic [7:0]  HOLD_LD  = 8'(E_LOW_CYC - 1);
    localparam logic [15:0] PLIM     = 16'(POLL_LIMIT);

    state_t      state, next_state;
    logic [7:0]  cyc_cnt, cyc_load;
    logic [15:0] poll_cnt;
    logic        rs_cap, poll_cap;
    logic        rs_q, rw_q, e_q, timeout_q, bf_q;
    logic [7:0]  rd_q;
    logic [6:0]  addr_q;
    logic        sample, in_access, rs_next, repoll;

    assign sample = (state == EHIGH) && (cyc_cnt == 8'd0);
    assign repoll = poll_cap && !rs_cap && rd_q[7] && (poll_cnt < PLIM);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.req) next_state = SETUP;
            SETUP:   if (cyc_cnt == 8'd0) next_state = EHIGH;
            EHIGH:   if (cyc_cnt == 8'd0) next_state = HOLD;
            HOLD:    if (cyc_cnt == 8'd0) next_state = repoll ? SETUP : DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        cyc_load = 8'd0;
        case (next_state)
            SETUP:   cyc_load = SETUP_LD;
            EHIGH:   cyc_load = EHIGH_LD;
            HOLD:    cyc_load = HOLD_LD;
            default: cyc_load = 8'd0;
        endcase
    end

    // Bus controls are registered from the next state so E/RW/RS never glitch
    assign in_access = (next_state == SETUP) || (next_state == EHIGH) || (next_state == HOLD);
    assign rs_next   = (state == IDLE) ? bus.rs_sel : rs_cap;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cyc_cnt   <= 8'd0;
            poll_cnt  <= 16'd0;
            rs_cap    <= 1'b0;
            poll_cap  <= 1'b0;
            rs_q      <= 1'b0;
            rw_q      <= 1'b0;
            e_q       <= 1'b0;
            timeout_q <= 1'b0;
            rd_q      <= 8'd0;
            bf_q      <= 1'b0;
            addr_q    <= 7'd0;
        end else begin
            state <= next_state;
            if (next_state != state)
                cyc_cnt <= cyc_load;
            else if (cyc_cnt != 8'd0)
                cyc_cnt <= cyc_cnt - 8'd1;

            if (state == IDLE && bus.req) begin
                rs_cap   <= bus.rs_sel;
                poll_cap <= bus.poll;
                poll_cnt <= 16'd0;
            end

            // Poll count tracks completed reads, so POLL_LIMIT bounds the strobe count
            if (sample) begin
                rd_q <= bus.DB_in;
                if (!rs_cap) begin
                    bf_q   <= bus.DB_in[7];
                    addr_q <= bus.DB_in[6:0];
                end
                if (poll_cnt != 16'hFFFF)
                    poll_cnt <= poll_cnt + 16'd1;
            end

            rs_q      <= in_access ? rs_next : 1'b0;
            rw_q      <= in_access;
            e_q       <= (next_state == EHIGH);
            timeout_q <= (state == HOLD) && (next_state == DONE) && poll_cap && !rs_cap && rd_q[7];
        end
    end

    assign bus.RS        = rs_q;
    assign bus.RW        = rw_q;
    assign bus.E         = e_q;
    assign bus.rd_data   = rd_q;
    assign bus.busy_flag = bf_q;
    assign bus.addr      = addr_q;
    assign bus.done      = (state == DONE);
    assign bus.timeout   = timeout_q;
    assign bus.idle      = (state == IDLE);
endmodule

// File: tb/tb_lcd_reader.sv
// tb/tb_lcd_reader.sv - self-checking bench for lcd_reader
module tb_lcd_reader;
    localparam int LIMIT  = 4;
    localparam int PER_RD = 27;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lcd_reader_if bus();

    lcd_reader #(.SETUP_CYC(2), .E_HIGH_CYC(12), .E_LOW_CYC(13), .POLL_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          rs;
        bit          pl;
        logic [31:0] v;
        logic [7:0]  rd;
        bit          bf;
        logic [6:0]  ad;
        bit          to;
        int          n;
    } vec_t;

    vec_t tbl[7];

    logic       m_bf;
    logic [6:0] m_addr;

    // Reference: strobe count is the first read with BF clear, capped at the poll limit
    task automatic model(input bit rs, input bit pl, input logic [31:0] v,
                         output int n, output logic [7:0] rd, output bit to);
        logic [7:0] b;
        bit found;
        found = 0;
        n = 1;
        if (!rs && pl) begin
            n = LIMIT;
            for (int i = 0; i < LIMIT; i++) begin
                b = v[8*i +: 8];
                if (!found && !b[7]) begin
                    n = i + 1;
                    found = 1;
                end
            end
        end
        rd = v[8*(n-1) +: 8];
        to = !rs && pl && rd[7];
    endtask

    task automatic run_vec(input string tag, input bit rs, input bit pl, input logic [31:0] v,
                           input logic [7:0] e_rd, input bit e_bf, input logic [6:0] e_ad,
                           input bit e_to, input int e_n);
        int n, done_c, hi, bad_len, rs_bad, first_rise;
        logic prev_e, to;
        n = 0; done_c = -1; hi = 0; bad_len = 0; rs_bad = 0; first_rise = -1;
        prev_e = 0; to = 0;
        @(negedge clk);
        bus.req = 1; bus.rs_sel = rs; bus.poll = pl; bus.DB_in = 8'h00;
        @(posedge clk);
        @(negedge clk);
        bus.req = 0; bus.rs_sel = ~rs; bus.poll = 1'($urandom);
        for (int c = 0; c < 400 && done_c < 0; c++) begin
            if (c > 0) @(negedge clk);
            if (bus.E && !prev_e) begin
                if (n == 0) first_rise = c;
                bus.DB_in = (n < 4) ? v[8*n +: 8] : 8'hEE;
                n++;
                hi = 0;
            end
            if (bus.E) begin
                hi++;
                if (bus.RS !== rs || bus.RW !== 1'b1) rs_bad++;
                bus.req = 1'($urandom);
            end else begin
                bus.req = 0;
            end
            if (!bus.E && prev_e && hi != 12) bad_len++;
            if (bus.done === 1'b1) begin
                done_c = c;
                to = bus.timeout;
                check({tag, ".rw_at_done"}, bus.RW, 0);
            end
            prev_e = bus.E;
        end
        bus.req = 0;
        bus.DB_in = 8'($urandom);
        check({tag, ".strobes"}, n, e_n);
        check({tag, ".latency"}, done_c, PER_RD * e_n);
        check({tag, ".e_rise"}, first_rise, 2);
        check({tag, ".e_width"}, bad_len, 0);
        check({tag, ".rs_rw"}, rs_bad, 0);
        check({tag, ".rd_data"}, bus.rd_data, e_rd);
        check({tag, ".busy_flag"}, bus.busy_flag, e_bf);
        check({tag, ".addr"}, bus.addr, e_ad);
        check({tag, ".timeout"}, to, e_to);
        @(negedge clk);
        check({tag, ".done_pulse"}, {bus.done, bus.idle}, 2'b01);
    endtask

    initial begin
        int n, dones, idles, runs, lim;
        logic [7:0] rd, b;
        logic [31:0] v;
        bit to, rs, pl, prev_idle;

        tbl[0] = '{1'b0, 1'b0, 32'h00000025, 8'h25, 1'b0, 7'h25, 1'b0, 1};
        tbl[1] = '{1'b1, 1'b0, 32'h000000C1, 8'hC1, 1'b0, 7'h25, 1'b0, 1};
        tbl[2] = '{1'b0, 1'b1, 32'h10808080, 8'h10, 1'b0, 7'h10, 1'b0, 4};
        tbl[3] = '{1'b0, 1'b1, 32'hFFFFFFFF, 8'hFF, 1'b1, 7'h7F, 1'b1, 4};
        tbl[4] = '{1'b1, 1'b1, 32'h00000080, 8'h80, 1'b1, 7'h7F, 1'b0, 1};
        tbl[5] = '{1'b0, 1'b0, 32'h0000009A, 8'h9A, 1'b1, 7'h1A, 1'b0, 1};
        tbl[6] = '{1'b0, 1'b1, 32'h77770580, 8'h05, 1'b0, 7'h05, 1'b0, 2};

        bus.req = 0; bus.rs_sel = 0; bus.poll = 0; bus.DB_in = 8'h00;
        repeat (3) @(negedge clk);
        check("reset.rs", bus.RS, 0);
        check("reset.rw", bus.RW, 0);
        check("reset.e", bus.E, 0);
        check("reset.rd_data", bus.rd_data, 0);
        check("reset.bf_addr", {bus.busy_flag, bus.addr}, 0);
        check("reset.done_to", {bus.done, bus.timeout}, 0);
        check("reset.idle", bus.idle, 1);
        rst = 1;

        for (int i = 0; i < 7; i++)
            run_vec($sformatf("tbl%0d", i), tbl[i].rs, tbl[i].pl, tbl[i].v,
                    tbl[i].rd, tbl[i].bf, tbl[i].ad, tbl[i].to, tbl[i].n);

        // Reset while E is high: immediate drop, no done, request discarded
        @(negedge clk);
        bus.req = 1; bus.rs_sel = 0; bus.poll = 1; bus.DB_in = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        bus.req = 0;
        repeat (5) @(negedge clk);
        check("rst_mid.e_before", bus.E, 1);
        #1 rst = 0;
        #1;
        check("rst_mid.e_rw", {bus.E, bus.RW}, 2'b00);
        check("rst_mid.idle", bus.idle, 1);
        @(negedge clk);
        rst = 1;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("rst_mid.no_done", dones, 0);
        check("rst_mid.regs", {bus.rd_data, bus.busy_flag, bus.addr}, 0);
        run_vec("after_rst", 1'b0, 1'b0, 32'h00000042, 8'h42, 1'b0, 7'h42, 1'b0, 1);
        m_bf = 0; m_addr = 7'h42;

        for (int i = 0; i < 60; i++) begin
            rs = 1'($urandom); pl = 1'($urandom);
            for (int k = 0; k < 4; k++) begin
                b = 8'($urandom);
                b[7] = ($urandom_range(9) < 7);
                v[8*k +: 8] = b;
            end
            model(rs, pl, v, n, rd, to);
            if (!rs) begin
                m_bf = rd[7];
                m_addr = rd[6:0];
            end
            run_vec($sformatf("rnd%0d", i), rs, pl, v, rd, m_bf, m_addr, to, n);
        end

        // req held high: back-to-back reads, one idle cycle between them
        @(negedge clk);
        bus.req = 1; bus.rs_sel = 0; bus.poll = 0; bus.DB_in = 8'h33;
        @(posedge clk);
        dones = 0; idles = 0; runs = 0; prev_idle = 0;
        for (int c = 0; c <= 115; c++) begin
            @(negedge clk);
            if (bus.done) dones++;
            if (bus.idle) begin
                idles++;
                if (prev_idle) runs++;
            end
            prev_idle = bus.idle;
        end
        bus.req = 0;
        lim = 0;
        while (!bus.idle && lim < 60) begin
            @(negedge clk);
            lim++;
        end
        check("b2b.dones", dones, 4);
        check("b2b.idles", idles, 4);
        check("b2b.idle_runs", runs, 0);
        check("b2b.settled", bus.idle, 1);
        check("b2b.addr", {bus.busy_flag, bus.addr}, 8'h33);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
